// File: rtl/ysyx_25050141_mem_arbiter.sv
// Single-port data-memory arbiter between instruction fetch (read-only) and the memory stage.
// ME has priority; a saturating starvation counter forces an IF grant after STARVE_LIMIT ME wins.
module ysyx_25050141_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_resp_valid,
  output logic [XLEN-1:0] if_resp_data,
  input  logic            me_req_valid,
  output logic            me_req_ready,
  input  logic [XLEN-1:0] me_req_addr,
  input  logic            me_req_wen,
  input  logic [XLEN-1:0] me_req_wdata,
  input  logic [3:0]      me_req_wmask,
  output logic            me_resp_valid,
  output logic [XLEN-1:0] me_resp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [3:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            owner_me_q, owner_me_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            wen_q, wen_d;
  logic [3:0]      wmask_q, wmask_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] me_rdata_q, me_rdata_d;

  logic idle, if_force, me_win, if_win;

  assign idle     = (state_q == S_IDLE);
  assign if_force = if_req_valid && (starve_cnt_q == LIMIT);
  assign me_win   = me_req_valid && !if_force;
  assign if_win   = if_req_valid && !me_win;

  // rst_n gating keeps the ready outputs low while reset is asserted
  assign me_req_ready = idle && rst_n && me_win;
  assign if_req_ready = idle && rst_n && if_win;

  always_comb begin
    state_d      = state_q;
    owner_me_d   = owner_me_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wen_d        = wen_q;
    wmask_d      = wmask_q;
    if_rdata_d   = if_rdata_q;
    me_rdata_d   = me_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (me_req_ready) begin
          owner_me_d = 1'b1;
          addr_d     = me_req_addr;
          wen_d      = me_req_wen;
          wdata_d    = me_req_wdata;
          wmask_d    = me_req_wmask;
          state_d    = S_ISSUE;
          if (if_req_valid && (starve_cnt_q != LIMIT)) starve_cnt_d = starve_cnt_q + CW'(1);
        end else if (if_req_ready) begin
          owner_me_d   = 1'b0;
          addr_d       = if_req_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = 4'b0000;
          starve_cnt_d = '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          if (owner_me_q) me_rdata_d = wen_q ? '0 : mem_resp_data;
          else            if_rdata_d = mem_resp_data;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_me_q   <= 1'b0;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      wmask_q      <= 4'b0000;
      if_rdata_q   <= '0;
      me_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_me_q   <= owner_me_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      wmask_q      <= wmask_d;
      if_rdata_q   <= if_rdata_d;
      me_rdata_q   <= me_rdata_d;
    end
  end

  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign if_resp_valid = (state_q == S_RESP) && !owner_me_q;
  assign me_resp_valid = (state_q == S_RESP) && owner_me_q;
  assign if_resp_data  = if_rdata_q;
  assign me_resp_data  = me_rdata_q;
  assign busy          = !idle;

endmodule

// File: tb/tb_ysyx_25050141_mem_arbiter.sv
// Bench for the IF/ME memory arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of the grant rule and response contents.
module tb_ysyx_25050141_mem_arbiter;
  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            if_req_valid = 1'b0, if_req_ready;
  logic [XLEN-1:0] if_req_addr = '0;
  logic            if_resp_valid;
  logic [XLEN-1:0] if_resp_data;
  logic            me_req_valid = 1'b0, me_req_ready;
  logic [XLEN-1:0] me_req_addr = '0;
  logic            me_req_wen = 1'b0;
  logic [XLEN-1:0] me_req_wdata = '0;
  logic [3:0]      me_req_wmask = '0;
  logic            me_resp_valid;
  logic [XLEN-1:0] me_resp_data;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_wen;
  logic [XLEN-1:0] mem_req_wdata;
  logic [3:0]      mem_req_wmask;
  logic            mem_resp_valid = 1'b0;
  logic [XLEN-1:0] mem_resp_data = '0;
  logic            busy;

  ysyx_25050141_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .me_req_valid(me_req_valid), .me_req_ready(me_req_ready), .me_req_addr(me_req_addr),
    .me_req_wen(me_req_wen), .me_req_wdata(me_req_wdata), .me_req_wmask(me_req_wmask),
    .me_resp_valid(me_resp_valid), .me_resp_data(me_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state: consecutive ME wins over a waiting IF, and last delivered data
  int          mdl_starve = 0;
  logic [31:0] mdl_if_data = '0;
  logic [31:0] mdl_me_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic scramble_inputs();
    if_req_valid  = 1'($urandom);
    if_req_addr   = $urandom;
    me_req_valid  = 1'($urandom);
    me_req_addr   = $urandom;
    me_req_wen    = 1'($urandom);
    me_req_wdata  = $urandom;
    me_req_wmask  = 4'($urandom);
    mem_resp_data = $urandom;
  endtask

  // One full transaction. Returns which requester the DUT granted.
  task automatic txn(input bit iv, input logic [31:0] ia,
                     input bit mv, input logic [31:0] ma, input bit mw,
                     input logic [31:0] md, input logic [3:0] mk,
                     input int k, input bit spur, input int m,
                     input logic [31:0] rd, input bit hold, output bit got_me);
    bit exp_me;
    logic [31:0] ea, er;
    bit ew;
    logic [3:0] ek;
    @(negedge clk);
    if_req_valid = iv; if_req_addr = ia;
    me_req_valid = mv; me_req_addr = ma; me_req_wen = mw; me_req_wdata = md; me_req_wmask = mk;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_if_resp_valid", if_resp_valid, 0);
    chk("idle_me_resp_valid", me_resp_valid, 0);
    chk("idle_if_data_held", if_resp_data, mdl_if_data);
    chk("idle_me_data_held", me_resp_data, mdl_me_data);
    exp_me = mv && !(iv && mdl_starve == LIMIT);
    chk("grant_if_ready", if_req_ready, iv && !exp_me);
    chk("grant_me_ready", me_req_ready, exp_me);
    got_me = me_req_ready;
    if (exp_me) begin
      if (iv && mdl_starve < LIMIT) mdl_starve++;
    end else mdl_starve = 0;
    ea = exp_me ? ma : ia;
    ew = exp_me ? mw : 1'b0;
    ek = exp_me ? mk : 4'b0000;
    er = (exp_me && mw) ? 32'h0 : rd;

    @(negedge clk);
    if (!hold) scramble_inputs();
    for (int i = 0; i <= k; i++) begin
      #1;
      chk("issue_valid", mem_req_valid, 1);
      chk("issue_addr", mem_req_addr, ea);
      chk("issue_wen", mem_req_wen, ew);
      chk("issue_wmask", mem_req_wmask, ek);
      if (exp_me) chk("issue_wdata", mem_req_wdata, md);
      chk("issue_ready_low", {if_req_ready, me_req_ready}, 0);
      chk("issue_no_resp", {if_resp_valid, me_resp_valid}, 0);
      mem_resp_valid = spur && (i < k);
      mem_req_ready  = (i == k);
      @(negedge clk);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    for (int i = 0; i < m; i++) begin
      #1;
      chk("wait_valid_low", mem_req_valid, 0);
      chk("wait_busy", busy, 1);
      chk("wait_no_resp", {if_resp_valid, me_resp_valid}, 0);
      @(negedge clk);
    end
    #1;
    chk("wait_valid_low", mem_req_valid, 0);
    mem_resp_valid = 1'b1; mem_resp_data = rd;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_data = $urandom;
    #1;
    if (exp_me) mdl_me_data = er; else mdl_if_data = er;
    chk("resp_if_valid", if_resp_valid, !exp_me);
    chk("resp_me_valid", me_resp_valid, exp_me);
    chk("resp_if_data", if_resp_data, mdl_if_data);
    chk("resp_me_data", me_resp_data, mdl_me_data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit g;
    bit [5:0] order;
    bit [5:0] exp_order;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_addr", mem_req_addr, 0);
    rst_n = 1'b1;

    // spurious memory response while idle
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_resp", {if_resp_valid, me_resp_valid}, 0);

    // single IF read
    txn(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 2, 32'h0000_0413, 0, g);
    chk("if_read_owner", g, 0);
    // ME store stalled in ISSUE for 3 cycles, spurious responses there
    txn(0, 0, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 3, 1, 1, 32'hCAFE_F00D, 0, g);
    chk("me_store_owner", g, 1);
    // ME load
    txn(0, 0, 1, 32'h8000_2004, 0, 0, 4'b1111, 0, 0, 0, 32'hA5A5_0101, 0, g);
    // simultaneous request: ME first, then IF
    txn(1, 32'h8000_0004, 1, 32'h8000_3000, 0, 0, 4'b1111, 1, 0, 1, 32'h0BAD_F00D, 1, g);
    chk("simul_me_first", g, 1);
    txn(1, 32'h8000_0004, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0013, 0, g);
    chk("simul_if_next", g, 0);

    // both held valid: grant order ME x4, IF, ME
    exp_order = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      txn(1, 32'h8000_0100 + 32'(i * 4), 1, 32'h8000_4000 + 32'(i * 4), 1'($urandom), $urandom,
          4'b1111, int'($urandom_range(0, 2)), 0, int'($urandom_range(0, 2)), $urandom, 1, g);
      order[i] = g;
    end
    chk("starve_order", 32'(order), 32'(exp_order));

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      bit iv, mv;
      iv = 1'($urandom);
      mv = 1'($urandom);
      if (!iv && !mv) iv = 1'b1;
      txn(iv, $urandom, mv, $urandom, 1'($urandom), $urandom, 4'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)), $urandom, 0, g);
    end

    // reset during WAIT aborts the transaction
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h8000_0040;
    me_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mem_valid", mem_req_valid, 0);
    chk("arst_mem_fields", {mem_req_addr[27:0], mem_req_wen, mem_req_wmask}, 0);
    chk("arst_mem_wdata", mem_req_wdata, 0);
    chk("arst_resp_valid", {if_resp_valid, me_resp_valid}, 0);
    chk("arst_if_data", if_resp_data, 0);
    chk("arst_me_data", me_resp_data, 0);
    chk("arst_ready", {if_req_ready, me_req_ready}, 0);
    mdl_starve = 0; mdl_if_data = '0; mdl_me_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_0000;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("late_resp_busy", busy, 0);
    chk("late_resp_valid", {if_resp_valid, me_resp_valid}, 0);
    @(negedge clk);
    #1;
    chk("late_resp_valid2", {if_resp_valid, me_resp_valid}, 0);
    chk("late_resp_if_data", if_resp_data, 0);

    // traffic resumes after reset with a fresh starvation count
    txn(1, 32'h8000_0080, 1, 32'h8000_5000, 0, 0, 4'b0001, 0, 0, 0, 32'h0000_00FF, 0, g);
    chk("post_rst_me_wins", g, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
